// File: rtl/branch_cmp_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : branch_cmp_unit                                             |
// | Purpose  : Registered RV32I branch resolution with redirect PC,        |
// |            valid/ready output stage and saturating retire statistics.  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module branch_cmp_unit #(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 16,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      cmpop,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] target,
  input  logic            pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            br_en,
  output logic            mispredict,
  output logic            illegal,
  output logic [XLEN-1:0] redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  localparam logic [XLEN-1:0]  c_pc_step = XLEN'(PC_STEP);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic            w_eq;
  logic            w_lt_s;
  logic            w_lt_u;
  logic            w_br_en;
  logic            w_illegal;
  logic            w_mispredict;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_accept;
  logic            w_retire;

  logic             r_out_valid;
  logic             r_br_en;
  logic             r_mispredict;
  logic             r_illegal;
  logic [XLEN-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_mis_count;

  assign w_eq   = (rs1 == rs2);
  assign w_lt_s = ($signed(rs1) < $signed(rs2));
  assign w_lt_u = (rs1 < rs2);

  always_comb begin
    w_br_en   = 1'b0;
    w_illegal = 1'b0;
    case (cmpop)
      3'b000:  w_br_en = w_eq;
      3'b001:  w_br_en = !w_eq;
      3'b100:  w_br_en = w_lt_s;
      3'b101:  w_br_en = !w_lt_s;
      3'b110:  w_br_en = w_lt_u;
      3'b111:  w_br_en = !w_lt_u;
      default: w_illegal = 1'b1;
    endcase
  end

  // An illegal op never counts as a mispredict, whatever the prediction.
  assign w_mispredict  = !w_illegal && (w_br_en != pred_taken);
  assign w_redirect_pc = w_br_en ? target : (pc + c_pc_step);

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_retire = r_out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_br_en       <= 1'b0;
      r_mispredict  <= 1'b0;
      r_illegal     <= 1'b0;
      r_redirect_pc <= '0;
      r_br_count    <= '0;
      r_mis_count   <= '0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept) begin
        r_br_en       <= w_br_en;
        r_mispredict  <= w_mispredict;
        r_illegal     <= w_illegal;
        r_redirect_pc <= w_redirect_pc;
      end

      // Counters see the retiring (held) result, not the one being loaded.
      if (w_retire) begin
        if (!r_illegal && !(&r_br_count)) begin
          r_br_count <= r_br_count + c_cnt_one;
        end
        if (r_mispredict && !(&r_mis_count)) begin
          r_mis_count <= r_mis_count + c_cnt_one;
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign br_en       = r_br_en;
  assign mispredict  = r_mispredict;
  assign illegal     = r_illegal;
  assign redirect_pc = r_redirect_pc;
  assign br_count    = r_br_count;
  assign mis_count   = r_mis_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_cmp_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_branch_cmp_unit                                          |
// | Purpose  : Directed self-checking bench for branch_cmp_unit.           |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_branch_cmp_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  cmpop;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] pc;
  logic [31:0] target;
  logic        pred_taken;
  logic        out_valid;
  logic        out_ready;
  logic        br_en;
  logic        mispredict;
  logic        illegal;
  logic [31:0] redirect_pc;
  logic [15:0] br_count;
  logic [15:0] mis_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic        s_br_en;
  logic        s_mispredict;
  logic        s_illegal;
  logic [31:0] s_redirect_pc;
  logic [1:0]  s_br_count;
  logic [1:0]  s_mis_count;

  int checks;
  int failures;

  branch_cmp_unit #(.XLEN(32), .CNT_W(16), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .cmpop(cmpop), .rs1(rs1), .rs2(rs2), .pc(pc), .target(target),
    .pred_taken(pred_taken), .out_valid(out_valid), .out_ready(out_ready),
    .br_en(br_en), .mispredict(mispredict), .illegal(illegal),
    .redirect_pc(redirect_pc), .br_count(br_count), .mis_count(mis_count)
  );

  // Narrow-counter copy sharing the same stimulus, used for saturation.
  branch_cmp_unit #(.XLEN(32), .CNT_W(2), .PC_STEP(4)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .cmpop(cmpop), .rs1(rs1), .rs2(rs2), .pc(pc), .target(target),
    .pred_taken(pred_taken), .out_valid(s_out_valid), .out_ready(out_ready),
    .br_en(s_br_en), .mispredict(s_mispredict), .illegal(s_illegal),
    .redirect_pc(s_redirect_pc), .br_count(s_br_count), .mis_count(s_mis_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] c_ops    [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
  logic       c_ops_br [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p,
                       input logic [31:0] t, input logic pt);
    in_valid   = v;
    cmpop      = op;
    rs1        = a;
    rs2        = b;
    pc         = p;
    target     = t;
    pred_taken = pt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    checks++; if ({br_en, mispredict, illegal} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%0b exp=000", {br_en, mispredict, illegal}); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect got=%0h exp=0", redirect_pc); end
    checks++; if (br_count !== 16'h0 || mis_count !== 16'h0) begin failures++; $display("FAIL reset_counts got=%0h/%0h exp=0/0", br_count, mis_count); end
  endtask

  // All six ops streamed back-to-back with out_ready held high.
  task automatic test_ops_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, c_ops[i], 32'hFFFF_FFFF, 32'h0000_0001, 32'h40, 32'h80, 1'b0);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ops_valid[%0d] got=%0h exp=1", i, out_valid); end
      checks++; if (br_en !== c_ops_br[i]) begin failures++; $display("FAIL ops_br_en[%0d] got=%0h exp=%0h", i, br_en, c_ops_br[i]); end
      checks++; if (redirect_pc !== (c_ops_br[i] ? 32'h80 : 32'h44)) begin failures++; $display("FAIL ops_redirect[%0d] got=%0h", i, redirect_pc); end
    end
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ops_drain got=%0h exp=0", out_valid); end
    checks++; if (br_count !== 16'd6 || mis_count !== 16'd3) begin failures++; $display("FAIL ops_counts got=%0d/%0d exp=6/3", br_count, mis_count); end
  endtask

  task automatic test_mispredict();
    do_reset();
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 32'd5, 32'd5, 32'h100, 32'h200, 1'b1);
    @(posedge clk); #1;
    checks++; if (br_en !== 1'b0 || mispredict !== 1'b1) begin failures++; $display("FAIL mis_flags got=%0b%0b exp=01", br_en, mispredict); end
    checks++; if (redirect_pc !== 32'h104) begin failures++; $display("FAIL mis_redirect got=%0h exp=104", redirect_pc); end
    checks++; if (mis_count !== 16'd0) begin failures++; $display("FAIL mis_before_retire got=%0d exp=0", mis_count); end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (mis_count !== 16'd1 || br_count !== 16'd1) begin failures++; $display("FAIL mis_after_retire got=%0d/%0d exp=1/1", br_count, mis_count); end
  endtask

  task automatic test_wrap_illegal();
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h40, 1'b0);
    @(posedge clk); #1;
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL wrap_redirect got=%0h exp=0", redirect_pc); end
    checks++; if (br_en !== 1'b0 || mispredict !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL wrap_flags got=%0b%0b%0b exp=000", br_en, mispredict, illegal); end
    @(negedge clk);
    drive(1'b1, 3'b011, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'h40, 1'b1);
    @(posedge clk); #1;
    checks++; if (illegal !== 1'b1 || mispredict !== 1'b0 || br_en !== 1'b0) begin failures++; $display("FAIL illegal_flags got=%0b%0b%0b exp=100", illegal, mispredict, br_en); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (br_count !== 16'd1 || mis_count !== 16'd0) begin failures++; $display("FAIL illegal_counts got=%0d/%0d exp=1/0", br_count, mis_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 32'd3, 32'd3, 32'h0, 32'h1000, 1'b1);
    @(posedge clk); #1;
    checks++; if (redirect_pc !== 32'h1000) begin failures++; $display("FAIL bp_first got=%0h exp=1000", redirect_pc); end
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'd3, 32'd3, 32'h0, 32'h1010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%0h exp=0", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || redirect_pc !== 32'h1000 || br_en !== 1'b1) begin failures++; $display("FAIL bp_frozen[%0d] got=%0h/%0h exp=1/1000", i, out_valid, redirect_pc); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 3'b000, 32'd3, 32'd3, 32'h0, 32'h1000 + 32'(i) * 32'h10, 1'b1);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || redirect_pc !== 32'h1000 + 32'(i) * 32'h10) begin failures++; $display("FAIL bp_order[%0d] got=%0h", i, redirect_pc); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || br_count !== 16'd4 || mis_count !== 16'd0) begin failures++; $display("FAIL bp_final got=%0h/%0d/%0d exp=0/4/0", out_valid, br_count, mis_count); end
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    drive(1'b1, 3'b001, 32'd1, 32'd2, 32'h10, 32'h20, 1'b0);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_held got=%0h exp=1", out_valid); end
    @(negedge clk);
    out_ready = 1'b1;
    flush     = 1'b1;
    drive(1'b1, 3'b001, 32'd1, 32'd2, 32'h30, 32'h40, 1'b0);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", out_valid); end
    checks++; if (br_count !== 16'd0 || mis_count !== 16'd0) begin failures++; $display("FAIL flush_counts got=%0d/%0d exp=0/0", br_count, mis_count); end
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || br_count !== 16'd0) begin failures++; $display("FAIL flush_after got=%0h/%0d exp=0/0", out_valid, br_count); end
  endtask

  task automatic test_saturation_async_reset();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 3'b001, 32'd1, 32'd2, 32'h0, 32'h8, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_br_count !== 2'd3 || s_mis_count !== 2'd3) begin failures++; $display("FAIL sat_counts got=%0d/%0d exp=3/3", s_br_count, s_mis_count); end
    checks++; if (br_count !== 16'd5 || mis_count !== 16'd5) begin failures++; $display("FAIL wide_counts got=%0d/%0d exp=5/5", br_count, mis_count); end
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'd9, 32'd9, 32'h0, 32'h500, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL arst_handshake got=%0h/%0h exp=0/1", out_valid, in_ready); end
    checks++; if ({br_en, mispredict, illegal} !== 3'b000 || redirect_pc !== 32'h0) begin failures++; $display("FAIL arst_data got=%0b/%0h exp=000/0", {br_en, mispredict, illegal}, redirect_pc); end
    checks++; if (br_count !== 16'd0 || mis_count !== 16'd0 || s_br_count !== 2'd0) begin failures++; $display("FAIL arst_counts got=%0d/%0d/%0d exp=0", br_count, mis_count, s_br_count); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    test_reset();
    test_ops_back_to_back();
    test_mispredict();
    test_wrap_illegal();
    test_backpressure();
    test_flush();
    test_saturation_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_cmp_unit.md
# branch_cmp_unit

Registered, parametrised branch-resolution stage for the pipelined core. It evaluates the six RV32I conditional-branch conditions on XLEN-wide operands and compares the outcome against the front-end prediction. It then produces a one-cycle-latency result with a valid/ready handshake, a redirect PC, and saturating branch/mispredict statistics counters. It sits between the EX operand muxes and the fetch-redirect logic, and it replaces the purely combinational compare used in earlier generations.

## Interface
- XLEN, 32, operand and PC width (≥ 8)
- CNT_W, 16, width of each statistics counter
- PC_STEP, 4, fall-through increment added to pc when the branch is not taken
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  kill the held result and any same-cycle input
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- cmpop  in  3  branch funct3 (beq 000, bne 001, blt 100, bge 101, bltu 110, bgeu 111)
- rs1  in  XLEN  first operand
- rs2  in  XLEN  second operand (register or immediate, already muxed)
- pc  in  XLEN  branch instruction PC
- target  in  XLEN  taken target
- pred_taken  in  1  front-end prediction
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  consumer accepts the result
- br_en  out  1  branch condition true
- mispredict  out  1  br_en != pred_taken
- illegal  out  1  cmpop is 010 or 011
- redirect_pc  out  XLEN  correct next PC
- br_count  out  CNT_W  branches retired, saturating
- mis_count  out  CNT_W  mispredicts retired, saturating

## Operation
- Combinational evaluation of the input request:
  - beq/bne: equality over all XLEN bits.
  - blt/bge: two's-complement signed compare.
  - bltu/bgeu: unsigned compare.
  - cmpop 010/011: br_en=0, illegal=1, mispredict forced to 0.
- redirect_pc = target if br_en, else pc+PC_STEP, computed modulo 2^XLEN (wraps).
- Single output register; in_ready = !out_valid | out_ready; accept = in_valid & in_ready & !flush.
- On accept, the output register loads the result fields and out_valid is set to 1.
- On out_valid & out_ready & !accept, out_valid clears.
- When the register is not loaded, its data fields hold their values; they are don't-care while out_valid=0.
- flush:
  - Forces out_valid to 0 on the next edge, overriding accept.
  - Suppresses counter updates for that cycle.
  - in_ready still follows its formula; the input is dropped.
- Retirement: a result retires when out_valid & out_ready & !flush.
  - On retirement, br_count increments when illegal=0, and mis_count increments when mispredict=1.
  - Each counter saturates at 2^CNT_W−1.
- Back-to-back: with out_ready held at 1, one result is produced per cycle, with no bubbles.

## Timing
- Latency: a request accepted at edge N is visible at the outputs after edge N, and is retired at the first edge with out_ready=1.
- All outputs are registered; none is combinational from in_* except in_ready, which depends only on out_valid and out_ready.
- Reset values: out_valid=0, br_en=0, mispredict=0, illegal=0, redirect_pc=0, br_count=0, mis_count=0; in_ready=1 follows from these.
- Reset asserted mid-operation clears state immediately (asynchronous), and any held result is lost.
- Simultaneous accept and retire in the same cycle: the counters update for the retiring result and the register loads the new one.
- Stalled output (out_ready=0): all outputs are stable, and in_ready=0.

## Test plan
- Ops sweep, one request each: rs1=0xFFFFFFFF, rs2=0x00000001 (XLEN=32).
  - Required: beq→0, bne→1, blt→1, bge→0, bltu→0, bgeu→1.
  - Each result appears on the cycle after accept with out_valid=1.
- Mispredict/redirect: bne with rs1=5, rs2=5, pc=0x100, target=0x200, pred_taken=1.
  - Required: br_en=0, mispredict=1, redirect_pc=0x104; mis_count goes 0→1 on retire.
- Wrap: beq, equal operands false, pc=0xFFFFFFFC.
  - Required: redirect_pc=0x00000000.
  - With cmpop=011: illegal=1, mispredict=0, br_count unchanged.
- Backpressure: stream 4 requests, hold out_ready=0 for 3 cycles after the first.
  - Required: in_ready=0 and outputs frozen during the stall.
  - All 4 results are delivered in order, with br_count=4 at the end.
- Flush: assert flush on the cycle a second request is presented while the first is held.
  - Required: out_valid=0 next cycle, neither result is counted, and the counters are unchanged.
- Saturation and reset: with CNT_W=2, retire 5 mispredicting branches.
  - Required: br_count=3, mis_count=3.
  - Assert rst asynchronously mid-stream: all outputs return to their reset values before the next clk edge.
